// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: 2-flop sync, shared tick prescaler, per-channel stability counter.
// Define SW_DEBOUNCE_EDGE_OUT_EN to generate rise_pulse/fall_pulse; otherwise both are tied to 0.
module sw_debounce #(
  parameter int WIDTH        = 10,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_TICKS - 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] state_dbg;
  logic [WIDTH-1:0] accept;

  assign tick = (presc == PRESC_MAX);

  // Per-channel state is implied by the sync2/db_out mismatch; exposed as a vector for probing.
  always_comb begin
    state_dbg = '0;
    accept    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_dbg[i] = (sync2[i] != db_out[i]) ? ST_PENDING : ST_IDLE;
      accept[i]    = (state_dbg[i] == ST_PENDING) && tick && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      presc  <= '0;
      db_out <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      presc <= tick ? '0 : presc + PW'(1);
      for (int i = 0; i < WIDTH; i++) begin
        case (state_dbg[i])
          ST_IDLE: cnt[i] <= '0;
          ST_PENDING: begin
            if (accept[i]) begin
              db_out[i] <= sync2[i];
              cnt[i]    <= '0;
            end else if (tick && (cnt[i] < CNT_MAX)) begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: cnt[i] <= '0;
        endcase
      end
    end
  end

`ifdef SW_DEBOUNCE_EDGE_OUT_EN
  // Pulses load on the same edge as db_out, so they line up with the level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= accept & sync2;
      fall_pulse <= accept & ~sync2;
    end
  end
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3); pulse expectations follow
// whether SW_DEBOUNCE_EDGE_OUT_EN is defined for the build.
module tb_sw_debounce;

  localparam int W       = 4;
  localparam int TD      = 4;
  localparam int ST      = 3;
  localparam int LAT_MIN = 11;
  localparam int LAT_MAX = 14;
  localparam int LAT_CAP = 40;
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] db_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  sw_debounce #(
    .WIDTH       (W),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .db_out    (db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pulse_exp(input logic [W-1:0] v);
    return EDGE_EN ? v : '0;
  endfunction

  // Waits for the next db_out change, then checks the new level, pulses, latency and pulse width.
  task automatic wait_db(input string tag, input logic [W-1:0] exp_db,
                         input logic [W-1:0] exp_rise, input logic [W-1:0] exp_fall);
    logic [W-1:0] prev;
    logic [W-1:0] e;
    int lat;
    prev = db_out;
    lat  = 0;
    exp_q.push_back(exp_db);
    do begin
      @(negedge clk);
      lat++;
    end while (db_out === prev && lat < LAT_CAP);
    e = exp_q.pop_front();
    check_val({tag, "_db"}, 32'(db_out), 32'(e));
    check_val({tag, "_rise"}, 32'(rise_pulse), 32'(exp_rise));
    check_val({tag, "_fall"}, 32'(fall_pulse), 32'(exp_fall));
    check_val($sformatf("%s_lat%0d_in_window", tag, lat),
              32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
    step(1);
    check_val({tag, "_rise_end"}, 32'(rise_pulse), 32'd0);
    check_val({tag, "_fall_end"}, 32'(fall_pulse), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) check_val("rise_fall_exclusive", 32'(rise_pulse & fall_pulse), 32'd0);
  end

  initial begin
    reset  = 1'b1;
    raw_in = '0;
    step(3);
    check_val("reset_db", 32'(db_out), 32'd0);
    check_val("reset_rise", 32'(rise_pulse), 32'd0);
    check_val("reset_fall", 32'(fall_pulse), 32'd0);
    reset = 1'b0;

    // clean step on bit 0, then release
    raw_in = 4'b0001;
    wait_db("clean", 4'b0001, pulse_exp(4'b0001), 4'b0000);
    raw_in = 4'b0000;
    wait_db("clean_off", 4'b0000, 4'b0000, pulse_exp(4'b0001));

    // bounce on bit 1: toggle every 3 clocks for 30 clocks, then hold 1
    for (int t = 0; t < 10; t++) begin
      raw_in[1] = ~raw_in[1];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check_val("bounce_hold", 32'({db_out, rise_pulse}), 32'd0);
      end
    end
    raw_in[1] = 1'b1;
    wait_db("bounce", 4'b0010, pulse_exp(4'b0010), 4'b0000);
    raw_in = 4'b0000;
    wait_db("bounce_off", 4'b0000, 4'b0000, pulse_exp(4'b0010));

    // 8-clock glitch on bit 2 must vanish
    raw_in = 4'b0100;
    for (int c = 0; c < 28; c++) begin
      if (c == 8) raw_in = 4'b0000;
      @(negedge clk);
      check_val("glitch", 32'({db_out, rise_pulse, fall_pulse}), 32'd0);
    end

    // simultaneous edges
    raw_in = 4'b1111;
    wait_db("simul_rise", 4'b1111, pulse_exp(4'b1111), 4'b0000);
    raw_in = 4'b0101;
    wait_db("simul_fall", 4'b0101, 4'b0000, pulse_exp(4'b1010));
    raw_in = 4'b0000;
    wait_db("simul_clear", 4'b0000, 4'b0000, pulse_exp(4'b0101));

    // reset while bit 3 is pending
    raw_in = 4'b1000;
    step(6);
    reset = 1'b1;
    step(1);
    check_val("midrst_db", 32'(db_out), 32'd0);
    check_val("midrst_rise", 32'(rise_pulse), 32'd0);
    check_val("midrst_fall", 32'(fall_pulse), 32'd0);
    reset = 1'b0;
    wait_db("post_rst", 4'b1000, pulse_exp(4'b1000), 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
